alu_wb_queue: RTL and testbench

ALU_WB_QUEUE -- requirements
Module: alu_wb_queue

---
 rtl/isa_pkg.sv | 12 +
 rtl/alu_wb_queue.sv | 139 +++++++++++++
 tb/tb_alu_wb_queue.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared ISA-level types for the execute/write-back datapath.
//   word_t    : 32-bit architectural data word
//   regbits_t : 5-bit register-file index (x0..x31)
// -----------------------------------------------------------------------------
package isa_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

endpackage : isa_pkg

// File: rtl/alu_wb_queue.sv
// -----------------------------------------------------------------------------
// alu_wb_queue
// Small FIFO between the ALU and the register-file write port. ALU results
// are queued with their destination index and overflow flag. The head entry is
// presented to the register file, and writes to x0 or of overflowing results
// are suppressed. A sticky overflow exception records the destination of the
// first overflowing result.
//
// Parameters
//   DEPTH       : queue entries, power of two in 2..16
// Ports
//   CLK         : clock, rising edge
//   nRST        : asynchronous active-low reset
//   in_valid    : ALU result present          in_ready  : queue not full
//   in_rd       : destination index           in_result : result value
//   in_overflow : result overflowed           flush     : discard all entries
//   wb_valid    : head entry present          wb_ready  : register file accepts head
//   wb_rd       : head destination index      wb_data   : head result
//   wb_wen      : register write enable for the head entry
//   ovf_flag    : sticky overflow exception   ovf_rd    : rd of first overflow
//   ovf_clear   : clears ovf_flag             count     : occupied entries
// -----------------------------------------------------------------------------
module alu_wb_queue
  import isa_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  regbits_t               in_rd,
  input  word_t                  in_result,
  input  logic                   in_overflow,
  input  logic                   flush,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output regbits_t               wb_rd,
  output word_t                  wb_data,
  output logic                   wb_wen,
  output logic                   ovf_flag,
  output regbits_t               ovf_rd,
  input  logic                   ovf_clear,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    regbits_t rd;
    word_t    result;
    logic     overflow;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            ovf_flag_q, ovf_flag_d;
  regbits_t        ovf_rd_q,   ovf_rd_d;

  logic   enq, deq;
  entry_t head;

  // Fullness depends only on the stored count, so a full queue refuses input
  // even in a cycle where the head is leaving.
  assign in_ready = (count_q < FULL);
  assign wb_valid = (count_q != '0);
  assign head     = mem[rd_ptr_q];

  // Flush overrides any same-cycle transfer in either direction.
  assign enq = in_valid & in_ready & ~flush;
  assign deq = wb_valid & wb_ready & ~flush;

  assign wb_rd    = head.rd;
  assign wb_data  = head.result;
  assign wb_wen   = wb_valid & (head.rd != '0) & ~head.overflow;
  assign ovf_flag = ovf_flag_q;
  assign ovf_rd   = ovf_rd_q;
  assign count    = count_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_flag_d = ovf_flag_q;
    ovf_rd_d   = ovf_rd_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly PW bits wide, so the increment wraps modulo DEPTH.
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // An overflowing enqueue in the same cycle as ovf_clear wins and
    // recaptures ovf_rd; otherwise the first overflow is kept.
    if (enq && in_overflow && (!ovf_flag_q || ovf_clear)) begin
      ovf_flag_d = 1'b1;
      ovf_rd_d   = in_rd;
    end else if (ovf_clear) begin
      ovf_flag_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (!nRST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_flag_q <= 1'b0;
      ovf_rd_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_flag_q <= ovf_flag_d;
      ovf_rd_q   <= ovf_rd_d;
    end
  end

  // NOTE: entry storage has no reset; count gates every read, so stale data is never visible.
  always_ff @(posedge CLK) begin
    if (enq) mem[wr_ptr_q] <= '{rd: in_rd, result: in_result, overflow: in_overflow};
  end

endmodule : alu_wb_queue

// File: tb/tb_alu_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_alu_wb_queue
// Scoreboard bench for alu_wb_queue (DEPTH = 4). A reference model holds the
// expected queue contents as a plain SystemVerilog queue and is updated at
// each rising edge from the applied inputs. A monitor on the falling edge
// compares every DUT output against the model. Directed scenarios are
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_alu_wb_queue;
  import isa_pkg::*;

  localparam int DEPTH = 4;

  logic                   CLK = 1'b0;
  logic                   nRST;
  logic                   in_valid, in_ready;
  regbits_t               in_rd;
  word_t                  in_result;
  logic                   in_overflow, flush;
  logic                   wb_valid, wb_ready;
  regbits_t               wb_rd;
  word_t                  wb_data;
  logic                   wb_wen, ovf_flag;
  regbits_t               ovf_rd;
  logic                   ovf_clear;
  logic [$clog2(DEPTH):0] count;

  alu_wb_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_result(in_result), .in_overflow(in_overflow), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_wen(wb_wen), .ovf_flag(ovf_flag),
    .ovf_rd(ovf_rd), .ovf_clear(ovf_clear), .count(count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned rd;
    int unsigned data;
    bit          ovf;
  } exp_t;

  exp_t        model_q[$];
  bit          m_ovf_flag;
  int unsigned m_ovf_rd;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: acceptance decisions come from the model's own occupancy.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      model_q.delete();
      m_ovf_flag = 1'b0;
      m_ovf_rd   = 0;
    end else begin
      bit was_full, accept;
      was_full = (model_q.size() == DEPTH);
      accept   = !flush && in_valid && !was_full;
      if (flush) model_q.delete();
      else begin
        if (wb_ready && model_q.size() > 0) void'(model_q.pop_front());
        if (accept) model_q.push_back('{rd: in_rd, data: in_result, ovf: in_overflow});
      end
      if (ovf_clear) m_ovf_flag = 1'b0;
      if (accept && in_overflow && !m_ovf_flag) begin
        m_ovf_flag = 1'b1;
        m_ovf_rd   = in_rd;
      end
    end
  end

  // Monitor: compare all outputs away from the active edge.
  always @(negedge CLK) begin
    if (nRST) begin
      check("count",    32'(count),    32'(model_q.size()));
      check("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
      check("wb_valid", 32'(wb_valid), 32'(model_q.size() != 0));
      check("ovf_flag", 32'(ovf_flag), 32'(m_ovf_flag));
      if (m_ovf_flag) check("ovf_rd", 32'(ovf_rd), m_ovf_rd);
      if (model_q.size() != 0) begin
        check("wb_rd",   32'(wb_rd), model_q[0].rd);
        check("wb_data", wb_data,    model_q[0].data);
        check("wb_wen",  32'(wb_wen),
              32'((model_q[0].rd != 0) && !model_q[0].ovf));
      end else begin
        check("wb_wen_empty", 32'(wb_wen), 32'(0));
      end
    end
  end

  // One cycle of stimulus: inputs change 1 time unit after the rising edge.
  task automatic cyc(input bit v, input int unsigned rd, input int unsigned res,
                     input bit ov, input bit wr, input bit fl, input bit clr);
    in_valid    = v;
    in_rd       = regbits_t'(rd);
    in_result   = res;
    in_overflow = ov;
    wb_ready    = wr;
    flush       = fl;
    ovf_clear   = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input bit wr);
    cyc(0, 0, 0, 0, wr, 0, 0);
  endtask

  initial begin
    nRST = 1'b0;
    in_valid = 0; in_rd = '0; in_result = '0; in_overflow = 0;
    wb_ready = 0; flush = 0; ovf_clear = 0;
    #2;
    check("rst_count",    32'(count),    32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_wb_valid", 32'(wb_valid), 32'(0));
    check("rst_wb_wen",   32'(wb_wen),   32'(0));
    check("rst_ovf_flag", 32'(ovf_flag), 32'(0));
    @(posedge CLK); #1;
    nRST = 1'b1;
    idle(0);

    // Single write, drained the following cycle.
    cyc(1, 5, 32'h0000_0010, 0, 1, 0, 0);
    check("single_valid", 32'(wb_valid), 32'(1));
    check("single_wen",   32'(wb_wen),   32'(1));
    check("single_data",  wb_data,       32'h10);
    idle(1);
    check("single_empty", 32'(count),    32'(0));

    // Fill with the head stalled; the fifth offer is ignored.
    for (int i = 0; i < 5; i++) cyc(1, 10 + i, 32'hA000_0000 + i, 0, 0, 0, 0);
    check("fill_count", 32'(count),    32'(4));
    check("fill_ready", 32'(in_ready), 32'(0));
    for (int i = 0; i < 5; i++) idle(1);
    check("drain_empty", 32'(count), 32'(0));

    // x0 destination and an overflowing result: both drop their write.
    cyc(1, 0, 32'h1234_5678, 0, 0, 0, 0);
    cyc(1, 7, 32'h7FFF_FFFF, 1, 0, 0, 0);
    check("ovf_flag_set", 32'(ovf_flag), 32'(1));
    check("ovf_rd_7",     32'(ovf_rd),   32'(7));
    cyc(1, 9, 32'h1, 1, 0, 0, 0);
    check("ovf_rd_kept",  32'(ovf_rd),   32'(7));
    for (int i = 0; i < 4; i++) idle(1);
    // Clear together with an overflowing enqueue: the enqueue wins.
    cyc(1, 3, 32'h5, 1, 1, 0, 1);
    check("ovf_clr_win",  32'(ovf_flag), 32'(1));
    check("ovf_rd_3",     32'(ovf_rd),   32'(3));
    cyc(0, 0, 0, 0, 1, 0, 1);
    check("ovf_cleared",  32'(ovf_flag), 32'(0));

    // Steady two-deep traffic across several pointer wraps.
    cyc(1, 1, 32'hB0, 0, 0, 0, 0);
    cyc(1, 2, 32'hB1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 3 + i, 32'hC0 + i, 0, 1, 0, 0);
      check("simul_count", 32'(count), 32'(2));
    end

    // Flush with a concurrent enqueue; set ovf first to prove it survives.
    cyc(1, 20, 32'hD0, 1, 0, 0, 0);
    check("pre_flush_count", 32'(count), 32'(3));
    cyc(1, 21, 32'hD1, 0, 1, 1, 0);
    check("flush_count", 32'(count),    32'(0));
    check("flush_valid", 32'(wb_valid), 32'(0));
    check("flush_ovf",   32'(ovf_flag), 32'(1));

    // Asynchronous reset between edges.
    cyc(1, 4, 32'hE0, 0, 0, 0, 0);
    cyc(1, 5, 32'hE1, 0, 0, 0, 0);
    check("pre_rst_count", 32'(count), 32'(2));
    #2;
    nRST = 1'b0;
    #1;
    check("arst_valid", 32'(wb_valid), 32'(0));
    check("arst_count", 32'(count),    32'(0));
    check("arst_ovf",   32'(ovf_flag), 32'(0));
    @(posedge CLK); #1;
    nRST = 1'b1;
    idle(0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 31), $urandom,
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 40) == 0), ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 6; i++) idle(1);
    check("final_empty", 32'(count), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_alu_wb_queue
